simplex_rx_lane_init: RTL and testbench
=======================================

Name: simplex_rx_lane_init

Overview:
- RX-side lane initialization controller for the simplex 8b/10b link.
- Consumes decoded receive characters from the 8b/10b decoder and sequences the lane through reset, comma alignment, bonding and verification.
- Drives the RX modport of simplex_operations_if, which reports link state back to the TX side.
- Monitors decode errors once the link is up and re-initializes the lane on excessive errors.

Parameters:
- RESET_CYCLES, 16, cycles the RST state holds reset asserted (min 1)
- ALIGN_COUNT, 4, consecutive error-free commas required to declare alignment
- VERIFY_COUNT, 64, /V/ characters required to declare verification
- VERIFY_ERR_MAX, 3, decode errors in VERIFY that force a return to RST
- STATE_TIMEOUT, 4096, max cycles in ALIGN, BOND or VERIFY before returning to RST
- ERR_WINDOW, 256, READY-state error monitoring window in cycles
- ERR_THRESH, 8, errors within one window that force a return to RST

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous active-high reset
- rx_data  input  8  decoded character
- rx_is_k  input  1  character is a K-code
- rx_valid  input  1  qualifies rx_data, rx_is_k, rx_code_err and rx_disp_err
- rx_code_err  input  1  invalid 10b code
- rx_disp_err  input  1  running-disparity error
- reinit_req  input  1  one-cycle request to re-initialize the lane
- ops  interface  -  simplex_operations_if.RX; drives aligned, bonded, verified, reset

Behaviour:
- Clocking and reset
  - Single clock domain: clk.
  - rst is synchronous and active-high.
  - While rst is high: state=RST, all counters cleared, reset=1, aligned=0, bonded=0, verified=0.
  - rst has priority over every other input.
- Definitions
  - err = rx_valid & (rx_code_err | rx_disp_err).
  - Characters (constants in the package): comma = K28.5 (0xBC), /A/ = K28.3 (0x7C), /V/ = K28.7 (0xFC).
  - A character is valid only when rx_valid=1, rx_is_k=1 and err=0.
  - Cycles with rx_valid=0 neither advance nor clear the character counters.
- Outputs
  - Moore outputs, registered, decoded from the state register.
  - An output changes on the same edge that enters the new state.
- FSM states
  - RST
    - reset=1, all other outputs 0.
    - After RESET_CYCLES cycles in RST, go to ALIGN.
  - ALIGN
    - reset=0.
    - Each valid comma increments the consecutive-comma counter.
    - Any err, or any valid non-comma character, clears the counter.
    - The edge that samples the ALIGN_COUNT-th consecutive comma goes to BOND.
  - BOND
    - aligned=1.
    - The first valid /A/ goes to VERIFY.
    - Commas and other characters are ignored.
    - Any err clears aligned and returns to ALIGN.
  - VERIFY
    - aligned=1, bonded=1.
    - Each valid /V/ increments the verify counter; other valid characters do not clear it.
    - Each err increments the error counter.
    - Error counter reaching VERIFY_ERR_MAX goes to RST; this check has priority over verify completion on the same edge.
    - Verify counter reaching VERIFY_COUNT goes to READY.
  - READY
    - aligned=1, bonded=1, verified=1.
    - Error monitor runs; on overflow, go to RST.
- Timeout
  - The timeout counter clears on every state entry.
  - Reaching STATE_TIMEOUT in ALIGN, BOND or VERIFY goes to RST.
- reinit_req
  - From any state other than RST, go to RST on the next edge.
  - In RST, restart the RESET_CYCLES count.
- Error monitor
  - Window counter free-runs 0..ERR_WINDOW-1 and wraps.
  - Error count clears on wrap; an err on the wrap cycle counts toward the new window.
  - Overflow pulses when the error count reaches ERR_THRESH.
- Counter widths: $clog2(param+1). All counters saturate and never wrap, except the window counter.
- Every entry to RST clears all counters and drops aligned, bonded and verified on that same edge.

Decomposition:
- simplex_pkg holds:
  - K-character constants K28_5, K28_3, K28_7
  - lane_state_t enum: RST, ALIGN, BOND, VERIFY, READY
- Sub-module simplex_err_monitor
  - Parameters: ERR_WINDOW, ERR_THRESH.
  - Ports: clk, rst, clr, err, overflow.
  - Instantiated once and held cleared outside READY.

Test Plan:
1. Release rst, then stream valid commas.
   - reset=1 for exactly 16 cycles.
   - aligned=1 on the edge sampling the 4th comma after leaving RST.
2. Commas, commas, comma with rx_disp_err, then 4 clean commas.
   - aligned rises only after the final 4 clean commas; the counter cleared on the error.
3. Aligned lane, send /A/, then 64 /V/ interleaved with data characters and rx_valid=0 gaps.
   - bonded=1 after /A/.
   - verified=1 exactly on the 64th /V/.
4. In VERIFY, inject 3 code errors.
   - Back to RST: reset=1, aligned, bonded and verified all 0.
   - Also case: 64th /V/ and 3rd error on the same edge ends in RST.
5. In READY, 7 errors in a 256-cycle window.
   - Stays READY.
   - 8 errors within one window returns to RST.
   - 7 errors straddling a wrap (4 before, 3 after) stays READY.
6. Sit in ALIGN sending only data characters.
   - RST after 4096 cycles.
   - reinit_req pulse in READY gives reset=1 on the next edge.
   - rst asserted mid-VERIFY clears all outputs the following edge.

Source files
------------

// File: rtl/simplex_rx_lane_init_pkg.sv
// Shared constants and types for the simplex 8b/10b lane logic.
package simplex_pkg;

    localparam logic [7:0] K28_5 = 8'hBC;  // comma
    localparam logic [7:0] K28_3 = 8'h7C;  // /A/
    localparam logic [7:0] K28_7 = 8'hFC;  // /V/

    typedef enum logic [2:0] {
        RST,
        ALIGN,
        BOND,
        VERIFY,
        READY
    } lane_state_t;

endpackage

// File: rtl/simplex_rx_lane_init_if.sv
// Link-state report from the RX lane controller to the TX side.
interface simplex_operations_if;

    logic aligned;
    logic bonded;
    logic verified;
    logic reset;

    modport RX (output aligned, output bonded, output verified, output reset);
    modport TX (input aligned, input bonded, input verified, input reset);

endinterface

// File: rtl/simplex_rx_lane_init_err_monitor.sv
// Windowed decode-error monitor: pulses overflow when ERR_THRESH errors land in one window.
module simplex_err_monitor #(
    parameter int unsigned ERR_WINDOW = 256,
    parameter int unsigned ERR_THRESH = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic err,
    output logic overflow
);

    localparam int unsigned WW = $clog2(ERR_WINDOW + 1);
    localparam int unsigned CW = $clog2(ERR_THRESH + 1);

    logic [WW-1:0] win;
    logic [CW-1:0] cnt;
    logic [CW-1:0] base;
    logic          wrap;

    assign wrap = (win == WW'(ERR_WINDOW - 1));
    // An error on the wrap cycle belongs to the window that starts there.
    assign base = wrap ? '0 : cnt;
    assign overflow = !clr && err && (base == CW'(ERR_THRESH - 1));

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            win <= '0;
            cnt <= '0;
        end else begin
            win <= wrap ? '0 : win + WW'(1);
            if (err && (base != CW'(ERR_THRESH))) begin
                cnt <= base + CW'(1);
            end else begin
                cnt <= base;
            end
        end
    end

endmodule

// File: rtl/simplex_rx_lane_init.sv
// RX lane initialization: reset, comma alignment, bonding, verification, then error-monitored READY.
module simplex_rx_lane_init
    import simplex_pkg::*;
#(
    parameter int unsigned RESET_CYCLES   = 16,
    parameter int unsigned ALIGN_COUNT    = 4,
    parameter int unsigned VERIFY_COUNT   = 64,
    parameter int unsigned VERIFY_ERR_MAX = 3,
    parameter int unsigned STATE_TIMEOUT  = 4096,
    parameter int unsigned ERR_WINDOW     = 256,
    parameter int unsigned ERR_THRESH     = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [7:0]           rx_data,
    input  logic                 rx_is_k,
    input  logic                 rx_valid,
    input  logic                 rx_code_err,
    input  logic                 rx_disp_err,
    input  logic                 reinit_req,
    simplex_operations_if.RX     ops
);

    localparam int unsigned RCW = $clog2(RESET_CYCLES + 1);
    localparam int unsigned ACW = $clog2(ALIGN_COUNT + 1);
    localparam int unsigned VCW = $clog2(VERIFY_COUNT + 1);
    localparam int unsigned ECW = $clog2(VERIFY_ERR_MAX + 1);
    localparam int unsigned TCW = $clog2(STATE_TIMEOUT + 1);

    lane_state_t    state;
    lane_state_t    nxt;
    logic [RCW-1:0] rst_cnt;
    logic [ACW-1:0] comma_cnt;
    logic [VCW-1:0] v_cnt;
    logic [ECW-1:0] e_cnt;
    logic [TCW-1:0] t_cnt;

    logic err, ch_ok, is_comma, is_a, is_v, timeout, overflow;

    assign err      = rx_valid && (rx_code_err || rx_disp_err);
    assign ch_ok    = rx_valid && !err;
    assign is_comma = ch_ok && rx_is_k && (rx_data == K28_5);
    assign is_a     = ch_ok && rx_is_k && (rx_data == K28_3);
    assign is_v     = ch_ok && rx_is_k && (rx_data == K28_7);
    assign timeout  = (t_cnt == TCW'(STATE_TIMEOUT - 1));

    simplex_err_monitor #(
        .ERR_WINDOW (ERR_WINDOW),
        .ERR_THRESH (ERR_THRESH)
    ) u_err_monitor (
        .clk      (clk),
        .rst      (rst),
        .clr      (state != READY),
        .err      (err),
        .overflow (overflow)
    );

    always_comb begin
        nxt = state;
        if (reinit_req && (state != RST)) begin
            nxt = RST;
        end else begin
            unique case (state)
                RST: if (!reinit_req && (rst_cnt == RCW'(RESET_CYCLES - 1))) nxt = ALIGN;
                ALIGN: begin
                    if (timeout) nxt = RST;
                    else if (is_comma && (comma_cnt == ACW'(ALIGN_COUNT - 1))) nxt = BOND;
                end
                BOND: begin
                    if (timeout) nxt = RST;
                    else if (err) nxt = ALIGN;
                    else if (is_a) nxt = VERIFY;
                end
                VERIFY: begin
                    // Error exhaustion wins over verify completion.
                    if (timeout) nxt = RST;
                    else if (err && (e_cnt == ECW'(VERIFY_ERR_MAX - 1))) nxt = RST;
                    else if (is_v && (v_cnt == VCW'(VERIFY_COUNT - 1))) nxt = READY;
                end
                READY: if (overflow) nxt = RST;
                default: nxt = RST;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= RST;
            rst_cnt      <= '0;
            comma_cnt    <= '0;
            v_cnt        <= '0;
            e_cnt        <= '0;
            t_cnt        <= '0;
            ops.reset    <= 1'b1;
            ops.aligned  <= 1'b0;
            ops.bonded   <= 1'b0;
            ops.verified <= 1'b0;
        end else begin
            state        <= nxt;
            ops.reset    <= (nxt == RST);
            ops.aligned  <= (nxt == BOND) || (nxt == VERIFY) || (nxt == READY);
            ops.bonded   <= (nxt == VERIFY) || (nxt == READY);
            ops.verified <= (nxt == READY);
            if ((nxt != state) || (state == RST && reinit_req)) begin
                rst_cnt   <= '0;
                comma_cnt <= '0;
                v_cnt     <= '0;
                e_cnt     <= '0;
                t_cnt     <= '0;
            end else begin
                if ((state != RST) && (state != READY) && !timeout) t_cnt <= t_cnt + TCW'(1);
                unique case (state)
                    RST: if (rst_cnt != RCW'(RESET_CYCLES)) rst_cnt <= rst_cnt + RCW'(1);
                    ALIGN: begin
                        if (is_comma) begin
                            if (comma_cnt != ACW'(ALIGN_COUNT)) comma_cnt <= comma_cnt + ACW'(1);
                        end else if (err || ch_ok) begin
                            comma_cnt <= '0;
                        end
                    end
                    VERIFY: begin
                        if (is_v && (v_cnt != VCW'(VERIFY_COUNT))) v_cnt <= v_cnt + VCW'(1);
                        if (err && (e_cnt != ECW'(VERIFY_ERR_MAX))) e_cnt <= e_cnt + ECW'(1);
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_simplex_rx_lane_init.sv
// Directed bench for simplex_rx_lane_init; outputs checked as {reset, aligned, bonded, verified}.
module tb_simplex_rx_lane_init;

    localparam logic [3:0] O_RST    = 4'b1000;
    localparam logic [3:0] O_ALIGN  = 4'b0000;
    localparam logic [3:0] O_BOND   = 4'b0100;
    localparam logic [3:0] O_VERIFY = 4'b0110;
    localparam logic [3:0] O_READY  = 4'b0111;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] rx_data;
    logic       rx_is_k, rx_valid, rx_code_err, rx_disp_err, reinit_req;
    int         tests = 0;
    int         fails = 0;

    simplex_operations_if ops ();

    simplex_rx_lane_init dut (
        .clk         (clk),
        .rst         (rst),
        .rx_data     (rx_data),
        .rx_is_k     (rx_is_k),
        .rx_valid    (rx_valid),
        .rx_code_err (rx_code_err),
        .rx_disp_err (rx_disp_err),
        .reinit_req  (reinit_req),
        .ops         (ops)
    );

    always #5 clk = ~clk;

    task automatic step(input logic [7:0] d, input logic k, input logic v, input logic ce,
                        input logic de);
        rx_data = d; rx_is_k = k; rx_valid = v; rx_code_err = ce; rx_disp_err = de;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        step(8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic kch(input logic [7:0] d);
        step(d, 1'b1, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic errc();
        step(8'h00, 1'b0, 1'b1, 1'b1, 1'b0);
    endtask

    task automatic chk(input string tag, input logic [3:0] exp);
        logic [3:0] obs;
        obs = {ops.reset, ops.aligned, ops.bonded, ops.verified};
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic goto_align();
        reinit_req = 1'b1;
        idle();
        reinit_req = 1'b0;
        chk("reinit_to_rst", O_RST);
        repeat (16) idle();
        chk("rst_to_align", O_ALIGN);
    endtask

    task automatic to_verify();
        goto_align();
        repeat (4) kch(8'hBC);
        kch(8'h7C);
        chk("enter_verify", O_VERIFY);
    endtask

    task automatic to_ready();
        to_verify();
        repeat (64) kch(8'hFC);
        chk("enter_ready", O_READY);
    endtask

    initial begin
        rst = 1'b1; reinit_req = 1'b0;
        rx_data = 8'h00; rx_is_k = 1'b0; rx_valid = 1'b0; rx_code_err = 1'b0; rx_disp_err = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_state", O_RST);

        // 1: reset held 16 cycles, then 4 commas align
        rst = 1'b0;
        for (int i = 1; i < 16; i++) begin
            kch(8'hBC);
            chk("rst_hold", O_RST);
        end
        kch(8'hBC);
        chk("rst_release", O_ALIGN);
        repeat (3) kch(8'hBC);
        chk("align_3_commas", O_ALIGN);
        kch(8'hBC);
        chk("align_4th_comma", O_BOND);

        // 2: error clears comma run; rx_valid gap does not
        goto_align();
        repeat (2) kch(8'hBC);
        step(8'hBC, 1'b1, 1'b1, 1'b0, 1'b1);
        repeat (3) kch(8'hBC);
        idle();
        chk("align_after_err_3", O_ALIGN);
        kch(8'hBC);
        chk("align_after_err_4", O_BOND);

        // BOND ignores commas and data, err returns to ALIGN
        kch(8'hBC);
        step(8'h55, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("bond_ignore", O_BOND);
        errc();
        chk("bond_err", O_ALIGN);
        repeat (4) kch(8'hBC);
        chk("rebond", O_BOND);

        // 3: /A/ then 64 /V/ mixed with data and gaps
        step(8'h7C, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("a_not_k", O_BOND);
        kch(8'h7C);
        chk("bond_a", O_VERIFY);
        for (int i = 0; i < 64; i++) begin
            kch(8'hFC);
            if (i == 62) chk("verify_63", O_VERIFY);
            if (i == 63) chk("verify_64", O_READY);
            if (i < 63) begin
                step(8'hFC, 1'b0, 1'b1, 1'b0, 1'b0);
                step(8'hFC, 1'b1, 1'b0, 1'b0, 1'b0);
            end
        end

        // 4: three errors in VERIFY
        to_verify();
        kch(8'hFC);
        errc();
        kch(8'hFC);
        errc();
        chk("verify_2_err", O_VERIFY);
        errc();
        chk("verify_3_err", O_RST);

        to_verify();
        repeat (63) kch(8'hFC);
        errc();
        errc();
        chk("v63_2err", O_VERIFY);
        step(8'hFC, 1'b1, 1'b1, 1'b1, 1'b0);
        chk("v64_err3_same", O_RST);

        to_verify();
        repeat (63) kch(8'hFC);
        errc();
        errc();
        kch(8'hFC);
        chk("v64_2err_ready", O_READY);

        // 5: READY error monitor; cycle k has window position k mod 256
        to_ready();
        for (int k = 0; k <= 787; k++) begin
            if ((k >= 251 && k <= 257) || (k >= 520 && k <= 526) || (k >= 780)) errc();
            else idle();
            if (k == 258) chk("mon_straddle", O_READY);
            if (k == 530) chk("mon_seven", O_READY);
            if (k == 786) chk("mon_seven_b", O_READY);
            if (k == 787) chk("mon_eight", O_RST);
        end

        // 6: ALIGN timeout after 4096 cycles
        goto_align();
        repeat (4095) step(8'h55, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("timeout_4095", O_ALIGN);
        step(8'h55, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("timeout_4096", O_RST);

        // reinit in RST restarts the count
        repeat (10) idle();
        reinit_req = 1'b1;
        idle();
        reinit_req = 1'b0;
        repeat (15) idle();
        chk("rst_restart_15", O_RST);
        idle();
        chk("rst_restart_16", O_ALIGN);

        to_ready();
        reinit_req = 1'b1;
        idle();
        reinit_req = 1'b0;
        chk("ready_reinit", O_RST);

        to_verify();
        repeat (10) kch(8'hFC);
        rst = 1'b1;
        kch(8'hFC);
        chk("rst_mid_verify", O_RST);
        rst = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
